// File: rtl/mfe_frame_io_if.sv
// Stream and memory-port bundle of the median-filter frame I/O controller.
// slave = the controller itself, master = its environment (source, engine, memories, sink).
interface mfe_frame_io_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              start;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] img_addr;
    logic [DATA_W-1:0] img_wdata;
    logic              img_wen;
    logic              mfe_ready;
    logic              mfe_busy;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_rdata;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              frame_done;

    modport slave (
        input  start, s_valid, s_data, mfe_busy, res_rdata, m_ready,
        output s_ready, img_addr, img_wdata, img_wen, mfe_ready, res_addr,
               m_valid, m_data, m_last, frame_done
    );

    modport master (
        output start, s_valid, s_data, mfe_busy, res_rdata, m_ready,
        input  s_ready, img_addr, img_wdata, img_wen, mfe_ready, res_addr,
               m_valid, m_data, m_last, frame_done
    );
endinterface

// File: rtl/mfe_frame_io.sv
// Frame I/O controller: loads a frame into image memory, kicks the filter engine, drains results.
// Optional MFE_IO_CHKSUM_EN adds a 16-bit sum of all output pixels of the frame.
module mfe_frame_io #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    mfe_frame_io_if.slave bus
`ifdef MFE_IO_CHKSUM_EN
    ,
    output logic [15:0]   chksum
`endif
);
    localparam int NPIX = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wcnt_reg;
    logic [ADDR_W-1:0] rcnt_reg;
    logic              rd_all_reg;
    logic              inflight_reg;
    logic              inflight_last_reg;
    logic [1:0]        fifo_cnt_reg;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [ADDR_W-1:0] img_addr_reg;
    logic [DATA_W-1:0] img_wdata_reg;
    logic              img_wen_reg;
    logic              frame_done_reg;

    logic              s_ready_c;
    logic              mfe_ready_c;
    logic              in_accept;
    logic              m_valid_c;
    logic              m_last_c;
    logic [DATA_W-1:0] m_data_c;
    logic              out_pop;
    logic              fifo_push;
    logic              rd_issue;
    logic [1:0]        occ_after;
    logic [1:0]        pending;
    logic              load_entry;
    logic              drain_entry;
    logic [DATA_W-1:0] head_data [2];
    logic              head_last [2];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        s_ready_c   = 1'b0;
        mfe_ready_c = 1'b0;
        in_accept   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready_c = 1'b1;
                in_accept = bus.s_valid;
                if (bus.s_valid && (wcnt_reg == LAST_ADDR)) state_next = ST_KICK;
            end
            ST_KICK: begin
                mfe_ready_c = 1'b1;
                if (bus.mfe_busy) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.mfe_busy) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_pop && m_last_c) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign load_entry  = (state_reg == ST_IDLE) && (state_next == ST_LOAD);
    assign drain_entry = (state_reg == ST_WAIT) && (state_next == ST_DRAIN);

    // ---------------------------------------------------------------- load path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_reg      <= '0;
            img_addr_reg  <= '0;
            img_wdata_reg <= '0;
            img_wen_reg   <= 1'b0;
        end else begin
            img_wen_reg <= in_accept;
            if (in_accept) begin
                img_addr_reg  <= wcnt_reg;
                img_wdata_reg <= bus.s_data;
            end
            if (load_entry) begin
                wcnt_reg <= '0;
            end else if (in_accept) begin
                wcnt_reg <= wcnt_reg + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- drain reads
    // The slot freed by this cycle's pop counts as available, otherwise the
    // 3-cycle issue/capture/pop loop could not sustain one pixel per cycle.
    always_comb begin
        occ_after = fifo_cnt_reg - {1'b0, out_pop};
        pending   = occ_after + {1'b0, inflight_reg};
        rd_issue  = (state_reg == ST_DRAIN) && !rd_all_reg && (pending < 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt_reg          <= '0;
            rd_all_reg        <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else if (drain_entry) begin
            rcnt_reg          <= '0;
            rd_all_reg        <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (rd_issue) begin
                rcnt_reg          <= rcnt_reg + 1'b1;
                inflight_last_reg <= (rcnt_reg == LAST_ADDR);
                if (rcnt_reg == LAST_ADDR) rd_all_reg <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- 2-entry skid FIFO
    assign fifo_push = inflight_reg;
    assign m_valid_c = (fifo_cnt_reg != 2'd0);
    assign out_pop   = m_valid_c && bus.m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_cnt_reg <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else if (drain_entry) begin
            fifo_cnt_reg <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (out_pop)   rd_ptr_reg <= ~rd_ptr_reg;
            case ({fifo_push, out_pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [DATA_W-1:0] data_reg;
        logic              last_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_reg <= '0;
                last_reg <= 1'b0;
            end else if (fifo_push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= bus.res_rdata;
                last_reg <= inflight_last_reg;
            end
        end

        assign head_data[gi] = data_reg;
        assign head_last[gi] = last_reg;
    end

    assign m_data_c = rd_ptr_reg ? head_data[1] : head_data[0];
    assign m_last_c = m_valid_c && (rd_ptr_reg ? head_last[1] : head_last[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= out_pop && m_last_c;
        end
    end

`ifdef MFE_IO_CHKSUM_EN
    logic [15:0] chksum_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chksum_reg <= 16'd0;
        end else if (drain_entry) begin
            chksum_reg <= 16'd0;
        end else if (out_pop) begin
            chksum_reg <= chksum_reg + 16'(m_data_c);
        end
    end

    assign chksum = chksum_reg;
`endif

    // ---------------------------------------------------------------- outputs
    assign bus.s_ready    = s_ready_c;
    assign bus.img_addr   = img_addr_reg;
    assign bus.img_wdata  = img_wdata_reg;
    assign bus.img_wen    = img_wen_reg;
    assign bus.mfe_ready  = mfe_ready_c;
    assign bus.res_addr   = rcnt_reg;
    assign bus.m_valid    = m_valid_c;
    assign bus.m_data     = m_data_c;
    assign bus.m_last     = m_last_c;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_mfe_frame_io.sv
// Directed bench for mfe_frame_io: load, engine handshake, drain (full rate, stalled),
// reset mid-drain and, with MFE_IO_CHKSUM_EN, the output checksum.
module tb_mfe_frame_io;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int NPIX   = 2 ** ADDR_W;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] res_mem [NPIX];

    mfe_frame_io_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MFE_IO_CHKSUM_EN
    logic [15:0] chksum;
`endif

    mfe_frame_io #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MFE_IO_CHKSUM_EN
        ,
        .chksum(chksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory with registered read
    always @(posedge clk) bus.res_rdata <= res_mem[bus.res_addr];

    task automatic fill_res(input bit ramp);
        for (int i = 0; i < NPIX; i++) res_mem[i] = ramp ? 8'(i) : 8'h5A;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        bus.mfe_busy = 1'b0; bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.s_ready, bus.img_wen, bus.mfe_ready, bus.m_valid, bus.m_last, bus.frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.s_ready, bus.img_wen, bus.mfe_ready, bus.m_valid, bus.m_last, bus.frame_done});
        end
        checks++;
        if ({bus.img_addr, bus.img_wdata, bus.res_addr, bus.m_data} !== '0) begin
            errors++;
            $display("FAIL reset_buses: img_addr=%0d img_wdata=%0h res_addr=%0d m_data=%0h expected all 0",
                     bus.img_addr, bus.img_wdata, bus.res_addr, bus.m_data);
        end
`ifdef MFE_IO_CHKSUM_EN
        checks++;
        if (chksum !== 16'h0) begin
            errors++;
            $display("FAIL reset_chksum: got %h expected 0000", chksum);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: s_ready=%b expected 0", bus.s_ready);
        end
        $display("[tb] test_reset done");
    endtask

    // Loads a ramp frame; optional s_valid gaps. Ends mid-way through the first KICK cycle.
    task automatic run_load(input string tag, input bit gaps);
        int acc = 0;
        int cyc = 0;
        int wen_cnt = 0;
        int wen_bad = 0;
        bit prev_acc = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (acc < NPIX && cyc < 2 * NPIX) begin
            bus.s_valid = !(gaps && (cyc % 16 == 15));
            bus.s_data  = 8'(acc);
            #1;
            if (bus.img_wen !== prev_acc) wen_bad++;
            if (bus.img_wen === 1'b1) begin
                if (bus.img_addr !== 14'(wen_cnt) || bus.img_wdata !== 8'(wen_cnt)) wen_bad++;
                wen_cnt++;
            end
            prev_acc = bus.s_valid && bus.s_ready;
            if (prev_acc) acc++;
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        #1;
        checks++;
        if (acc !== NPIX) begin
            errors++;
            $display("FAIL %s_accepted: got %0d beats expected %0d", tag, acc, NPIX);
        end
        checks++;
        if (bus.img_wen !== 1'b1 || bus.img_addr !== 14'h3FFF || bus.img_wdata !== 8'hFF) begin
            errors++;
            $display("FAIL %s_last_write: wen=%b addr=%0d data=%h expected 1/16383/ff",
                     tag, bus.img_wen, bus.img_addr, bus.img_wdata);
        end
        if (bus.img_wen === 1'b1) wen_cnt++;
        checks++;
        if (wen_cnt !== NPIX || wen_bad !== 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes (%0d bad) expected %0d (0 bad)", tag, wen_cnt, wen_bad, NPIX);
        end
        checks++;
        if (bus.s_ready !== 1'b0 || bus.mfe_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_to_kick: s_ready=%b mfe_ready=%b expected 0/1", tag, bus.s_ready, bus.mfe_ready);
        end
        $display("[tb] %s: %0d beats loaded in %0d cycles", tag, acc, cyc);
    endtask

    // Engine raises busy in the 3rd KICK cycle, holds it 6 cycles, then drops it.
    task automatic run_kick(input string tag);
        int hi = 0;
        int act = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.mfe_busy = (k >= 2 && k < 8);
                #1;
            end
            if (bus.mfe_ready === 1'b1) hi++;
            if (k >= 3 && (bus.mfe_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.img_wen !== 1'b0 ||
                           bus.s_ready !== 1'b0 || bus.res_addr !== 14'd0)) act++;
        end
        checks++;
        if (hi !== 3) begin
            errors++;
            $display("FAIL %s_mfe_ready_cycles: got %0d expected 3", tag, hi);
        end
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL %s_wait_quiet: got %0d active cycles expected 0", tag, act);
        end
        @(negedge clk);
        $display("[tb] %s: mfe_ready high %0d cycles", tag, hi);
    endtask

    // Starts at the first DRAIN cycle. rand_ready stalls randomly over the first 2048 beats.
    task automatic run_drain(input string tag, input bit rand_ready, input bit ramp,
                             input int abort_at, input bit poke_start);
        int beat = 0;
        int cyc = 0;
        int first_valid = -1;
        int gaps = 0;
        int bad_data = 0;
        int bad_last = 0;
        int bad_stable = 0;
        int fd_early = 0;
        int first_bad = -1;
        logic [7:0] bad_got = '0;
        logic [7:0] expd;
        logic [7:0] held_data = '0;
        logic held_last = 1'b0;
        bit stalled = 1'b0;
        bit done = 1'b0;
        while (!done && cyc < 4 * NPIX) begin
            bus.start   = poke_start && (cyc == 50);
            bus.m_ready = (rand_ready && beat < 2048) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.frame_done !== 1'b0) fd_early++;
            if (stalled && (bus.m_valid !== 1'b1 || bus.m_data !== held_data || bus.m_last !== held_last))
                bad_stable++;
            if (bus.m_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                expd = ramp ? 8'(beat) : 8'h5A;
                if (bus.m_data !== expd) begin
                    if (first_bad < 0) begin first_bad = beat; bad_got = bus.m_data; end
                    bad_data++;
                end
                if (bus.m_last !== (beat == NPIX - 1)) bad_last++;
                stalled   = !bus.m_ready;
                held_data = bus.m_data;
                held_last = bus.m_last;
                if (bus.m_ready) begin
                    beat++;
                    if (beat == NPIX) done = 1'b1;
                end
            end else begin
                stalled = 1'b0;
                if (first_valid >= 0) gaps++;
            end
            if (abort_at > 0 && beat == abort_at) break;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (first_valid !== 2) begin
            errors++;
            $display("FAIL %s_first_valid: got cycle %0d expected 2", tag, first_valid);
        end
        checks++;
        if (bad_data !== 0) begin
            errors++;
            $display("FAIL %s_data: %0d bad beats, first beat %0d got %h expected %h",
                     tag, bad_data, first_bad, bad_got, ramp ? 8'(first_bad) : 8'h5A);
        end
        checks++;
        if (bad_last !== 0 || fd_early !== 0) begin
            errors++;
            $display("FAIL %s_last_flags: m_last errors %0d early frame_done %0d expected 0/0",
                     tag, bad_last, fd_early);
        end
        if (rand_ready) begin
            checks++;
            if (bad_stable !== 0) begin
                errors++;
                $display("FAIL %s_stall_stable: got %0d unstable stalls expected 0", tag, bad_stable);
            end
        end else if (abort_at <= 0) begin
            checks++;
            if (gaps !== 0 || cyc !== NPIX + 2) begin
                errors++;
                $display("FAIL %s_throughput: gaps=%0d cycles=%0d expected 0/%0d", tag, gaps, cyc, NPIX + 2);
            end
        end
        if (abort_at <= 0) begin
            checks++;
            if (beat !== NPIX) begin
                errors++;
                $display("FAIL %s_beats: got %0d expected %0d", tag, beat, NPIX);
            end
            #1;
            checks++;
            if (bus.frame_done !== 1'b1 || bus.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_frame_done: frame_done=%b m_valid=%b expected 1/0", tag, bus.frame_done, bus.m_valid);
            end
`ifdef MFE_IO_CHKSUM_EN
            if (ramp) begin
                checks++;
                if (chksum !== 16'hE000) begin
                    errors++;
                    $display("FAIL %s_chksum: got %h expected e000", tag, chksum);
                end
            end
`endif
            @(negedge clk);
            #1;
            checks++;
            if (bus.frame_done !== 1'b0 || bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle_after: frame_done=%b s_ready=%b expected 0/0", tag, bus.frame_done, bus.s_ready);
            end
`ifdef MFE_IO_CHKSUM_EN
            if (ramp) begin
                checks++;
                if (chksum !== 16'hE000) begin
                    errors++;
                    $display("FAIL %s_chksum_hold: got %h expected e000", tag, chksum);
                end
            end
`endif
        end
        $display("[tb] %s: %0d beats out in %0d cycles", tag, beat, cyc);
    endtask

    task automatic test_load_kick_drain_const();
        fill_res(1'b0);
        run_load("load_ramp", 1'b0);
        run_kick("kick_a");
        run_drain("drain_const", 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        fill_res(1'b1);
        run_load("load_gaps", 1'b1);
        run_kick("kick_b");
        run_drain("drain_abort", 1'b0, 1'b1, 100, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        #1;
        checks++;
        if ({bus.s_ready, bus.img_wen, bus.mfe_ready, bus.m_valid, bus.m_last, bus.frame_done} !== 6'b0 ||
            {bus.img_addr, bus.img_wdata, bus.res_addr, bus.m_data} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: img_addr=%0d img_wdata=%h res_addr=%0d m_data=%h m_valid=%b expected all 0",
                     bus.img_addr, bus.img_wdata, bus.res_addr, bus.m_data, bus.m_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_start_ignored: s_ready=%b m_valid=%b expected 0/0", bus.s_ready, bus.m_valid);
        end
        $display("[tb] test_reset_mid_drain done");
    endtask

    task automatic test_random_drain();
        fill_res(1'b1);
        run_load("load_c", 1'b0);
        run_kick("kick_c");
        run_drain("drain_random", 1'b1, 1'b1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_kick_drain_const();
        test_reset_mid_drain();
        test_random_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
